// File: rtl/oled_pkg.sv
// Shared definitions for the PmodOLED receive model.
// Opcodes, FSM encoding and frame-buffer address width.
package oled_pkg;

   localparam int ADDR_W = 10;

   localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
   localparam logic [7:0] OP_DISP_ON     = 8'hAF;
   localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
   localparam logic [7:0] OP_CONTRAST    = 8'h81;
   localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
   localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
   localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
   localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
   localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
   localparam logic [7:0] OP_COM_PINS    = 8'hDA;
   localparam logic [7:0] OP_VCOMH       = 8'hDB;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_t;

   // Opcodes whose next command byte is an argument, not an opcode
   function automatic logic is_two_byte(input logic [7:0] op);
      case (op)
         OP_ADDR_MODE, OP_CONTRAST, OP_CHARGE_PUMP,
         OP_MUX_RATIO, OP_DISP_OFFSET, OP_CLK_DIV,
         OP_PRECHARGE, OP_COM_PINS, OP_VCOMH: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/oled_spi_rx_if.sv
// Serial link and frame-buffer/status bundle of the OLED receiver.
// master = OLED driver side, slave = receiver.
interface oled_spi_rx_if;
   import oled_pkg::*;

   logic              CS;
   logic              SCLK;
   logic              SDIN;
   logic              DC;
   logic              RES;
   logic [ADDR_W-1:0] FB_ADDR;
   logic [7:0]        FB_DATA;
   logic              FB_WE;
   logic              DISP_ON;
   logic              CMD_VALID;
   logic [7:0]        CMD_BYTE;
   logic [15:0]       BYTE_COUNT;

   modport master (
      output CS, SCLK, SDIN, DC, RES,
      input  FB_ADDR, FB_DATA, FB_WE, DISP_ON,
      input  CMD_VALID, CMD_BYTE, BYTE_COUNT
   );

   modport slave (
      input  CS, SCLK, SDIN, DC, RES,
      output FB_ADDR, FB_DATA, FB_WE, DISP_ON,
      output CMD_VALID, CMD_BYTE, BYTE_COUNT
   );

endinterface

// File: rtl/oled_spi_sync_edge.sv
// Synchronizer chains for the serial inputs plus edge strobes.
// SCLK rises only count while synchronized CS is low.
module oled_spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic cs,
   input  logic sclk,
   input  logic sdin,
   input  logic dc,
   input  logic res,
   output logic cs_s,
   output logic sdin_s,
   output logic dc_s,
   output logic res_s,
   output logic sclk_rise,
   output logic cs_rise,
   output logic cs_fall
);

   logic [SYNC_STAGES-1:0] cs_ff;
   logic [SYNC_STAGES-1:0] sclk_ff;
   logic [SYNC_STAGES-1:0] sdin_ff;
   logic [SYNC_STAGES-1:0] dc_ff;
   logic [SYNC_STAGES-1:0] res_ff;
   logic                   cs_p;
   logic                   sclk_p;
   logic                   sclk_s;

   // Shift raw inputs through the chains; idle values on reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         cs_ff   <= '1;
         sclk_ff <= '0;
         sdin_ff <= '0;
         dc_ff   <= '0;
         res_ff  <= '1;
         cs_p    <= 1'b1;
         sclk_p  <= 1'b0;
      end else begin
         cs_ff   <= {cs_ff[SYNC_STAGES-2:0], cs};
         sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
         sdin_ff <= {sdin_ff[SYNC_STAGES-2:0], sdin};
         dc_ff   <= {dc_ff[SYNC_STAGES-2:0], dc};
         res_ff  <= {res_ff[SYNC_STAGES-2:0], res};
         cs_p    <= cs_s;
         sclk_p  <= sclk_s;
      end
   end

   assign cs_s   = cs_ff[SYNC_STAGES-1];
   assign sclk_s = sclk_ff[SYNC_STAGES-1];
   assign sdin_s = sdin_ff[SYNC_STAGES-1];
   assign dc_s   = dc_ff[SYNC_STAGES-1];
   assign res_s  = res_ff[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_p & ~cs_s;
   assign cs_rise   = cs_s & ~cs_p;
   assign cs_fall   = ~cs_s & cs_p;

endmodule

// File: rtl/oled_spi_rx.sv
// PmodOLED (SSD1306-style) serial receiver with frame-buffer writes.
// Assembles MSB-first bytes, decodes commands, writes data bytes.
module oled_spi_rx
   import oled_pkg::*;
#(
   parameter int PAGES       = 4,
   parameter int COLS        = 128,
   parameter int SYNC_STAGES = 2
) (
   input logic          CLK,
   input logic          RST,
   oled_spi_rx_if.slave bus
);

   logic              cs_s;
   logic              sdin_s;
   logic              dc_s;
   logic              res_s;
   logic              sclk_rise;
   logic              cs_rise;
   logic              cs_fall;
   logic              rst_hit;
   logic              last_edge;
   logic [7:0]        byte_in;
   logic [ADDR_W-1:0] cur_addr;

   state_t            state;
   state_t            state_n;
   logic [6:0]        sr;
   logic [2:0]        bit_cnt;
   logic              dc_q;
   logic [2:0]        page;
   logic [6:0]        col;
   logic              arg_pending;
   logic [ADDR_W-1:0] fb_addr;
   logic [7:0]        fb_data;
   logic              fb_we;
   logic              disp_on;
   logic              cmd_valid;
   logic [7:0]        cmd_byte;
   logic [15:0]       byte_count;

   oled_spi_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .CLK      (CLK),
      .RST      (RST),
      .cs       (bus.CS),
      .sclk     (bus.SCLK),
      .sdin     (bus.SDIN),
      .dc       (bus.DC),
      .res      (bus.RES),
      .cs_s     (cs_s),
      .sdin_s   (sdin_s),
      .dc_s     (dc_s),
      .res_s    (res_s),
      .sclk_rise(sclk_rise),
      .cs_rise  (cs_rise),
      .cs_fall  (cs_fall)
   );

   assign rst_hit   = ~RST | ~res_s;
   assign last_edge = (state == ST_SHIFT) && sclk_rise
                      && (bit_cnt == 3'd7);
   assign byte_in   = {sr, sdin_s};
   assign cur_addr  = ADDR_W'(int'(page) * COLS + int'(col));

   // State register
   always_ff @(posedge CLK) begin
      if (rst_hit) state <= ST_IDLE;
      else         state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE: begin
            if (cs_fall) state_n = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cs_rise)        state_n = ST_IDLE;
            else if (last_edge) state_n = ST_COMMIT;
         end
         ST_COMMIT: begin
            state_n = cs_s ? ST_IDLE : ST_SHIFT;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Byte assembly, strobes and command/column state
   always_ff @(posedge CLK) begin
      if (rst_hit) begin
         sr          <= '0;
         bit_cnt     <= '0;
         dc_q        <= 1'b0;
         page        <= '0;
         col         <= '0;
         arg_pending <= 1'b0;
         fb_addr     <= '0;
         fb_data     <= '0;
         fb_we       <= 1'b0;
         disp_on     <= 1'b0;
         cmd_valid   <= 1'b0;
         cmd_byte    <= '0;
         byte_count  <= '0;
      end else begin
         fb_we     <= 1'b0;
         cmd_valid <= 1'b0;
         if (state == ST_SHIFT) begin
            if (cs_rise) begin
               bit_cnt <= '0;
            end else if (sclk_rise) begin
               sr      <= byte_in[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  dc_q <= dc_s;
                  if (dc_s) begin
                     fb_we   <= 1'b1;
                     fb_data <= byte_in;
                     fb_addr <= cur_addr;
                  end else begin
                     cmd_valid <= 1'b1;
                     cmd_byte  <= byte_in;
                  end
               end
            end
         end else if (state == ST_COMMIT) begin
            bit_cnt    <= '0;
            byte_count <= byte_count + 16'd1;
            if (dc_q) begin
               col <= (col == 7'(COLS - 1)) ? 7'd0 : col + 7'd1;
            end else if (arg_pending) begin
               arg_pending <= 1'b0;
            end else begin
               unique case (1'b1)
                  (cmd_byte == OP_DISP_OFF):    disp_on <= 1'b0;
                  (cmd_byte == OP_DISP_ON):     disp_on <= 1'b1;
                  (cmd_byte[7:3] == 5'b10110):
                     page <= 3'(int'(cmd_byte[2:0]) % PAGES);
                  (cmd_byte[7:4] == 4'h0):      col[3:0] <= cmd_byte[3:0];
                  (cmd_byte[7:3] == 5'b00010):  col[6:4] <= cmd_byte[2:0];
                  is_two_byte(cmd_byte):        arg_pending <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

   assign bus.FB_ADDR    = fb_addr;
   assign bus.FB_DATA    = fb_data;
   assign bus.FB_WE      = fb_we;
   assign bus.DISP_ON    = disp_on;
   assign bus.CMD_VALID  = cmd_valid;
   assign bus.CMD_BYTE   = cmd_byte;
   assign bus.BYTE_COUNT = byte_count;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx.
// Scoreboard of expected writes/commands from a small panel model.
module tb_oled_spi_rx;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   logic [17:0] exp_wr[$];
   logic [7:0]  exp_cmd[$];

   logic [2:0]  m_page;
   logic [6:0]  m_col;
   logic        m_arg;
   logic        m_disp;
   logic [15:0] m_cnt;

   oled_spi_rx_if bus();

   oled_spi_rx #(
      .PAGES      (4),
      .COLS       (128),
      .SYNC_STAGES(2)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_page = '0;
      m_col  = '0;
      m_arg  = 1'b0;
      m_disp = 1'b0;
      m_cnt  = '0;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic dc);
      logic [9:0] a;
      m_cnt = m_cnt + 16'd1;
      if (dc) begin
         a = {1'b0, m_page[1:0], m_col};
         exp_wr.push_back({a, b});
         m_col = (m_col == 7'd127) ? 7'd0 : m_col + 7'd1;
      end else begin
         exp_cmd.push_back(b);
         if (m_arg) m_arg = 1'b0;
         else if (b == 8'hAE) m_disp = 1'b0;
         else if (b == 8'hAF) m_disp = 1'b1;
         else if (b inside {[8'hB0:8'hB7]}) m_page = 3'(b[2:0] % 4);
         else if (b inside {[8'h00:8'h0F]}) m_col[3:0] = b[3:0];
         else if (b inside {[8'h10:8'h17]}) m_col[6:4] = b[2:0];
         else if (b inside {8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                            8'hD5, 8'hD9, 8'hDA, 8'hDB}) m_arg = 1'b1;
      end
   endtask

   task automatic shift_bits(input logic [7:0] b, input int n,
                             input logic dc, input int half);
      for (int i = 7; i > 7 - n; i--) begin
         bus.SDIN = b[i];
         bus.DC   = dc;
         repeat (half) @(negedge clk);
         bus.SCLK = 1'b1;
         repeat (half) @(negedge clk);
         bus.SCLK = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc);
      model_byte(b, dc);
      shift_bits(b, 8, dc, 4);
   endtask

   task automatic cs_low();
      bus.CS = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (6) @(negedge clk);
      bus.CS = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Scoreboard: compare every strobe against the expected queues
   always @(negedge clk) begin
      logic [17:0] ew;
      logic [7:0]  ec;
      if (bus.FB_WE || bus.CMD_VALID)
         chk("we_and_cmd", 32'(bus.FB_WE & bus.CMD_VALID), 0);
      if (bus.FB_WE) begin
         if (exp_wr.size() == 0) begin
            chk("fb_we_unexpected", 32'(bus.FB_WE), 0);
         end else begin
            ew = exp_wr.pop_front();
            chk("fb_addr", 32'(bus.FB_ADDR), 32'(ew[17:8]));
            chk("fb_data", 32'(bus.FB_DATA), 32'(ew[7:0]));
         end
      end
      if (bus.CMD_VALID) begin
         if (exp_cmd.size() == 0) begin
            chk("cmd_unexpected", 32'(bus.CMD_VALID), 0);
         end else begin
            ec = exp_cmd.pop_front();
            chk("cmd_byte", 32'(bus.CMD_BYTE), 32'(ec));
         end
      end
   end

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      rst      = 1'b0;
      bus.CS   = 1'b1;
      bus.SCLK = 1'b0;
      bus.SDIN = 1'b0;
      bus.DC   = 1'b0;
      bus.RES  = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      chk("rst_fb_we", 32'(bus.FB_WE), 0);
      chk("rst_cmd_valid", 32'(bus.CMD_VALID), 0);
      chk("rst_disp_on", 32'(bus.DISP_ON), 0);
      chk("rst_byte_count", 32'(bus.BYTE_COUNT), 0);
      chk("rst_fb_addr", 32'(bus.FB_ADDR), 0);
      chk("rst_cmd_byte", 32'(bus.CMD_BYTE), 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // Page/column setup then one data byte at 0x135
      cs_low();
      send_byte(8'hB2, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h13, 1'b0);
      send_byte(8'hA5, 1'b1);
      cs_high();
      chk("byte_count_4", 32'(bus.BYTE_COUNT), 32'(m_cnt));
      chk("cmd_byte_held", 32'(bus.CMD_BYTE), 32'h13);

      // Column wrap at 127 keeps the page
      cs_low();
      send_byte(8'hB1, 1'b0);
      send_byte(8'h0F, 1'b0);
      send_byte(8'h17, 1'b0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      cs_high();

      // 0xAF swallowed as charge-pump argument, then honoured
      cs_low();
      send_byte(8'h8D, 1'b0);
      send_byte(8'hAF, 1'b0);
      cs_high();
      chk("disp_after_arg", 32'(bus.DISP_ON), 32'(m_disp));
      cs_low();
      send_byte(8'hAF, 1'b0);
      cs_high();
      chk("disp_on", 32'(bus.DISP_ON), 32'(m_disp));

      // Partial byte aborted by CS rise
      cs_low();
      shift_bits(8'hFF, 5, 1'b1, 4);
      cs_high();
      cs_low();
      send_byte(8'h3C, 1'b1);
      cs_high();
      chk("count_after_abort", 32'(bus.BYTE_COUNT), 32'(m_cnt));

      // RES pulse mid-byte
      cs_low();
      shift_bits(8'hF0, 4, 1'b1, 4);
      bus.RES = 1'b0;
      repeat (3) @(negedge clk);
      bus.RES = 1'b1;
      model_reset();
      repeat (6) @(negedge clk);
      chk("res_disp_on", 32'(bus.DISP_ON), 0);
      chk("res_byte_count", 32'(bus.BYTE_COUNT), 0);
      cs_high();
      cs_low();
      send_byte(8'h77, 1'b1);
      cs_high();

      // Write-strobe latency with SCLK at CLK/4
      cs_low();
      model_byte(8'hC3, 1'b1);
      shift_bits(8'hC3, 7, 1'b1, 2);
      bus.SDIN = 1'b1;
      repeat (2) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (2) @(negedge clk);
      chk("we_lat_early", 32'(bus.FB_WE), 0);
      @(negedge clk);
      chk("we_lat_exact", 32'(bus.FB_WE), 1);
      bus.SCLK = 1'b0;
      @(negedge clk);
      chk("we_lat_one_cycle", 32'(bus.FB_WE), 0);
      cs_high();

      // RST held while the 8th edge arrives
      cs_low();
      shift_bits(8'h99, 7, 1'b1, 4);
      bus.SDIN = 1'b1;
      repeat (4) @(negedge clk);
      bus.SCLK = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rst_no_we", 32'(bus.FB_WE), 0);
         if (i == 2) bus.SCLK = 1'b0;
      end
      rst = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      chk("rst_count_zero", 32'(bus.BYTE_COUNT), 0);
      cs_high();
      cs_low();
      send_byte(8'h5A, 1'b1);
      cs_high();
      chk("final_count", 32'(bus.BYTE_COUNT), 32'(m_cnt));

      chk("wr_queue_drained", 32'(exp_wr.size()), 0);
      chk("cmd_queue_drained", 32'(exp_cmd.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- Receive-side model of the PmodOLED serial link (SSD1306-style, 128x32) for the emulation/verification build.
- Oversamples CS/SCLK/SDIN/DC/RES on the system clock and assembles MSB-first bytes.
- Decodes a command subset from the command bytes and writes data bytes into a frame-buffer BRAM at the current page/column.
- Acts as a loopback target for the OLED driver so display contents can be read back without a panel.

Parameters:
PAGES, 4, number of 8-row pages; frame buffer depth = PAGES*COLS.
COLS, 128, columns per page.
SYNC_STAGES, 2, flip-flop synchronizer depth on every serial input (min 2).

Ports:
CLK  input  1  system clock; must be at least 4x SCLK.
RST  input  1  synchronous reset, active-low.
CS  input  1  chip select, active-low.
SCLK  input  1  serial clock; data sampled on rising edge.
SDIN  input  1  serial data, MSB first.
DC  input  1  0 = command byte, 1 = data byte; sampled with bit 0.
RES  input  1  panel reset, active-low; same effect as RST.
FB_ADDR  output  10  frame-buffer address = page*COLS + column.
FB_DATA  output  8  byte written.
FB_WE  output  1  one-cycle write strobe.
DISP_ON  output  1  display-on flag.
CMD_VALID  output  1  one-cycle strobe per completed command byte (opcode or argument).
CMD_BYTE  output  8  last command byte, held until the next one.
BYTE_COUNT  output  16  total completed bytes since reset; wraps at 65535->0.

Behaviour:
- Reset (RST=0 or synchronized RES=0):
  - All outputs 0. page=0, col=0, bit_cnt=0, arg_pending=0, state IDLE. Synchronizers preset to CS=1, SCLK=0.
  - Reset has priority over every other event, including a byte completing in the same cycle.
- Input synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - Rising edge = synchronized SCLK is 1 and its previous value was 0. Only edges with synchronized CS=0 count.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT when CS falls.
  - SHIFT: on each rising edge, shift SDIN into sr[7:0] (MSB first) and increment bit_cnt. On the 8th edge, latch DC and go to COMMIT.
  - COMMIT (exactly one cycle): perform the byte action, clear bit_cnt, return to SHIFT (or IDLE if CS=1).
  - CS rising while in SHIFT: discard any partial byte (bit_cnt cleared, no strobe), go to IDLE.
- Latency: FB_WE or CMD_VALID asserts 1 CLK after the cycle in which the 8th synchronized rising edge is detected.
- Data byte (DC=1), FB_WE=1 for one cycle:
  - FB_ADDR = page*COLS + col, FB_DATA = byte.
  - Then col increments. At COLS-1, col wraps to 0 and page stays unchanged (page addressing mode).
- Command byte (DC=0), CMD_VALID=1 and CMD_BYTE=byte:
  - If arg_pending=1: the byte is an argument only. Clear arg_pending; no decode.
  - Otherwise decode:
    - 0xAE: DISP_ON=0. 0xAF: DISP_ON=1.
    - 0xB0-0xB7: page = byte[2:0] mod PAGES.
    - 0x00-0x0F: col[3:0] = byte[3:0].
    - 0x10-0x17: col[6:4] = byte[2:0].
    - Two-byte opcodes 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: set arg_pending=1.
    - All other opcodes: strobe only, no state change.
- BYTE_COUNT increments on every COMMIT, command or data.
- Multiple bytes within one CS-low window are supported, and DC may change between bytes.
- An SCLK edge coincident with a CS rise is ignored.
- FB_WE and CMD_VALID are never asserted together.

Decomposition:
- Shared package oled_pkg: SSD1306 opcode constants, the two-byte opcode list, FSM state encoding, and the FB_ADDR width (10).
- One sub-module: oled_spi_sync_edge. It holds the synchronizer chains for CS/SCLK/SDIN/DC/RES and produces sclk_rise, cs_rise and cs_fall strobes plus synchronized levels.
- Byte assembly and command decode stay in oled_spi_rx.

Test Plan:
- Send commands 0xB2, 0x05, 0x13 (DC=0), then data 0xA5 (DC=1) -> three CMD_VALID pulses; FB_WE once with FB_ADDR=2*128+0x35=0x135 and FB_DATA=0xA5; BYTE_COUNT=4.
- Page 1, col 127, data 0x11 then 0x22 -> writes at 0x0FF then 0x080 (column wrap, page unchanged).
- Send command 0x8D then 0xAF -> two CMD_VALID pulses and DISP_ON stays 0 (0xAF consumed as argument). Then send 0xAF -> DISP_ON=1.
- Shift 5 bits, raise CS, then send a full byte 0x3C with DC=1 -> exactly one FB_WE with data 0x3C; partial byte discarded.
- Pull RES low for 3 CLK mid-byte after DISP_ON=1 -> DISP_ON=0, BYTE_COUNT=0, next data byte lands at FB_ADDR=0.
- Drive SCLK at CLK/4 and check FB_WE rises exactly 1 CLK after the detected 8th edge. Hold RST=0 while a byte completes -> no strobe.
